// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: BTB branch-type encoding and RAS checkpoint layout.
package fetch_pkg;

   typedef enum logic [1:0] {
      BR_COND = 2'b00,
      BR_JUMP = 2'b01,
      BR_CALL = 2'b10,
      BR_RET  = 2'b11
   } br_type_t;

   localparam int unsigned RAS_DEPTH = 8;
   localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);

   typedef struct packed {
      logic [RAS_PTR_W:0]   count;
      logic [RAS_PTR_W-1:0] tos;
   } ras_ckpt_t;

endpackage

// File: rtl/return_addr_stack.sv
// Speculative return-address stack for fetch: push PC+4 on predicted calls, supply the
// top entry on predicted returns, restore {count,tos} from a checkpoint on flush.
module return_addr_stack
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH  = RAS_DEPTH,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CKPT_W = 2*PTR_W+1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_valid,
   input  br_type_t          pred_br_type,
   input  logic [31:0]       pred_pc,
   output logic              ret_valid,
   output logic [31:0]       ret_pc,
   output logic [CKPT_W-1:0] ckpt_out,
   input  logic              flush,
   input  logic [CKPT_W-1:0] flush_ckpt,
   input  br_type_t          flush_br_type,
   input  logic [31:0]       flush_pc,
   output logic              full,
   output logic              empty
);

   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] TOS_ONE = PTR_W'(1);

   logic [PTR_W-1:0] tos_q, tos_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic [31:0]      mem_q [DEPTH];

   logic [PTR_W-1:0] base_tos;
   logic [PTR_W:0]   base_cnt;
   logic             op_valid;
   br_type_t         op_type;
   logic [31:0]      op_pc;
   logic             push, pop;

   // Flush replaces both the base state and the operation; pred_* is dropped that cycle.
   always_comb begin
      base_tos = tos_q;
      base_cnt = cnt_q;
      op_valid = pred_valid;
      op_type  = pred_br_type;
      op_pc    = pred_pc;
      if (flush) begin
         base_cnt = flush_ckpt[CKPT_W-1:PTR_W];
         base_tos = flush_ckpt[PTR_W-1:0];
         op_valid = 1'b1;
         op_type  = flush_br_type;
         op_pc    = flush_pc;
      end

      push = op_valid && (op_type == BR_CALL);
      pop  = op_valid && (op_type == BR_RET) && (base_cnt != '0);

      tos_d = base_tos;
      cnt_d = base_cnt;
      if (push) begin
         tos_d = base_tos + TOS_ONE;
         cnt_d = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_ONE;
      end else if (pop) begin
         tos_d = base_tos - TOS_ONE;
         cnt_d = base_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tos_q <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         tos_q <= tos_d;
         cnt_q <= cnt_d;
         if (push) mem_q[tos_d] <= op_pc + 32'd4;
      end
   end

   always_comb begin
      ret_pc    = mem_q[tos_q];
      ret_valid = (cnt_q != '0);
      ckpt_out  = {cnt_q, tos_q};
      full      = (cnt_q == CNT_MAX);
      empty     = (cnt_q == '0);
   end

endmodule
